// File: rtl/sdio_data_sequencer.sv
// SDIO data-phase sequencer: moves bytes between the data phy and the function-side
// data multiplexer, counting bytes and blocks and collecting per-block CRC status on writes.
module sdio_data_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_write,
    input  logic        i_block_mode,
    input  logic [11:0] i_block_size,
    input  logic [8:0]  i_count,
    input  logic        i_abort,
    output logic        o_activate,
    output logic        o_wr_stb,
    output logic [7:0]  o_wr_data,
    output logic        o_hst_rdy,
    input  logic        i_rd_stb,
    input  logic [7:0]  i_rd_data,
    input  logic        i_com_rdy,
    input  logic        i_finished,
    input  logic        i_phy_wr_stb,
    input  logic [7:0]  i_phy_wr_data,
    output logic        o_phy_wr_rdy,
    output logic        o_phy_rd_stb,
    output logic [7:0]  o_phy_rd_data,
    input  logic        i_phy_rd_rdy,
    output logic        o_block_end,
    input  logic        i_crc_ok,
    input  logic        i_crc_err,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] HST_LIMIT = (PTR_W+1)'(FIFO_DEPTH - 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_XFER     = 3'd1;
    localparam logic [2:0] S_BLK_WAIT = 3'd2;
    localparam logic [2:0] S_FINISH   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]       state;
    logic             write_q;
    logic             block_mode_q;
    logic [11:0]      block_size_q;
    logic [8:0]       count_q;
    logic [11:0]      byte_cnt;
    logic [8:0]       block_cnt;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   fifo_cnt;

    logic [11:0]      blk_len;
    logic             last_byte;
    logic             in_xfer;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_accept;
    logic             rd_push_try;
    logic             rd_push;
    logic             rd_pop;
    logic             xfer_byte;
    logic             final_on_end;
    logic             final_in_wait;
    logic             start_bad;
    logic             fifo_clear;

    // Byte mode is a single block of i_count bytes, where a count of zero stands for 512.
    assign blk_len       = block_mode_q ? block_size_q
                         : ((count_q == 9'd0) ? 12'd512 : {3'b000, count_q});
    assign last_byte     = (byte_cnt == blk_len - 12'd1);
    assign in_xfer       = (state == S_XFER);
    assign fifo_full     = (fifo_cnt == FULL_CNT);
    assign fifo_empty    = (fifo_cnt == '0);
    assign wr_accept     = in_xfer && write_q && i_com_rdy && i_phy_wr_stb;
    assign rd_push_try   = in_xfer && !write_q && i_rd_stb;
    assign rd_push       = rd_push_try && !fifo_full;
    assign rd_pop        = in_xfer && !write_q && !fifo_empty && i_phy_rd_rdy;
    assign xfer_byte     = wr_accept || rd_pop;
    assign final_on_end  = !block_mode_q || ((count_q != 9'd0) && (block_cnt + 9'd1 == count_q));
    assign final_in_wait = !block_mode_q || ((count_q != 9'd0) && (block_cnt == count_q));
    assign start_bad     = i_block_mode && ((i_block_size == 12'd0) || (i_block_size > 12'd2048));
    assign fifo_clear    = ((state == S_IDLE) && i_start)
                         || (i_abort && ((state == S_XFER) || (state == S_BLK_WAIT)));

    assign o_activate   = (state == S_XFER) || (state == S_BLK_WAIT);
    assign o_busy       = o_activate || (state == S_FINISH);
    assign o_done       = (state == S_DONE);
    assign o_phy_wr_rdy = in_xfer && write_q && i_com_rdy;
    assign o_hst_rdy    = in_xfer && !write_q && (fifo_cnt <= HST_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            write_q       <= 1'b0;
            block_mode_q  <= 1'b0;
            block_size_q  <= 12'd0;
            count_q       <= 9'd0;
            byte_cnt      <= 12'd0;
            block_cnt     <= 9'd0;
            o_wr_stb      <= 1'b0;
            o_wr_data     <= 8'd0;
            o_phy_rd_stb  <= 1'b0;
            o_phy_rd_data <= 8'd0;
            o_block_end   <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_wr_stb     <= 1'b0;
            o_phy_rd_stb <= 1'b0;
            o_block_end  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        write_q      <= i_write;
                        block_mode_q <= i_block_mode;
                        block_size_q <= i_block_size;
                        count_q      <= i_count;
                        byte_cnt     <= 12'd0;
                        block_cnt    <= 9'd0;
                        o_error      <= start_bad;
                        state        <= start_bad ? S_DONE : S_XFER;
                    end
                end
                S_XFER: begin
                    if (wr_accept) begin
                        o_wr_stb  <= 1'b1;
                        o_wr_data <= i_phy_wr_data;
                    end
                    if (rd_pop) begin
                        o_phy_rd_stb  <= 1'b1;
                        o_phy_rd_data <= mem[rd_ptr];
                    end
                    if (rd_push_try && fifo_full) begin
                        o_error <= 1'b1;
                    end
                    if (xfer_byte) begin
                        if (last_byte) begin
                            o_block_end <= 1'b1;
                            byte_cnt    <= 12'd0;
                            block_cnt   <= block_cnt + 9'd1;
                            if (write_q) begin
                                state <= S_BLK_WAIT;
                            end else if (final_on_end) begin
                                state <= S_FINISH;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 12'd1;
                        end
                    end
                    // A byte handshaken in the abort cycle still completes; only the sequencing stops.
                    if (i_abort) begin
                        state <= S_FINISH;
                    end
                end
                S_BLK_WAIT: begin
                    if (i_abort) begin
                        state <= S_FINISH;
                    end else if (i_crc_err) begin
                        o_error <= 1'b1;
                        state   <= S_FINISH;
                    end else if (i_crc_ok) begin
                        state <= final_in_wait ? S_FINISH : S_XFER;
                    end
                end
                S_FINISH: begin
                    if (i_finished) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (rd_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({rd_push, rd_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            mem[wr_ptr] <= i_rd_data;
        end
    end

endmodule

// File: tb/tb_sdio_data_sequencer.sv
// Self-checking bench for sdio_data_sequencer: randomized transfers compared against
// byte/block expectations built from the transfer parameters.
module tb_sdio_data_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_write, i_block_mode, i_abort;
    logic [11:0] i_block_size;
    logic [8:0]  i_count;
    logic        o_activate, o_wr_stb, o_hst_rdy;
    logic [7:0]  o_wr_data;
    logic        i_rd_stb, i_com_rdy, i_finished;
    logic [7:0]  i_rd_data;
    logic        i_phy_wr_stb, o_phy_wr_rdy;
    logic [7:0]  i_phy_wr_data;
    logic        o_phy_rd_stb, i_phy_rd_rdy;
    logic [7:0]  o_phy_rd_data;
    logic        o_block_end, i_crc_ok, i_crc_err;
    logic        o_busy, o_done, o_error;

    int total = 0;
    int bad = 0;

    logic [7:0] rd_q[$];
    logic [7:0] wr_q[$];
    bit         rd_end_q[$];
    bit         wr_end_q[$];
    int         blk_ends;
    int         done_cnt;
    logic [7:0] exp_data[$];
    int         widx;

    sdio_data_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_write(i_write),
        .i_block_mode(i_block_mode), .i_block_size(i_block_size), .i_count(i_count),
        .i_abort(i_abort), .o_activate(o_activate), .o_wr_stb(o_wr_stb),
        .o_wr_data(o_wr_data), .o_hst_rdy(o_hst_rdy), .i_rd_stb(i_rd_stb),
        .i_rd_data(i_rd_data), .i_com_rdy(i_com_rdy), .i_finished(i_finished),
        .i_phy_wr_stb(i_phy_wr_stb), .i_phy_wr_data(i_phy_wr_data),
        .o_phy_wr_rdy(o_phy_wr_rdy), .o_phy_rd_stb(o_phy_rd_stb),
        .o_phy_rd_data(o_phy_rd_data), .i_phy_rd_rdy(i_phy_rd_rdy),
        .o_block_end(o_block_end), .i_crc_ok(i_crc_ok), .i_crc_err(i_crc_err),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    // Output collector: records every byte leaving the DUT together with its block-end flag.
    always @(negedge clk) begin
        if (o_wr_stb) begin
            wr_q.push_back(o_wr_data);
            wr_end_q.push_back(o_block_end);
        end
        if (o_phy_rd_stb) begin
            rd_q.push_back(o_phy_rd_data);
            rd_end_q.push_back(o_block_end);
        end
        if (o_block_end) blk_ends++;
        if (o_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete(); wr_q.delete(); rd_end_q.delete(); wr_end_q.delete();
        blk_ends = 0; done_cnt = 0;
    endtask

    task automatic fill_data(input int n);
        exp_data.delete();
        for (int i = 0; i < n; i++) exp_data.push_back(8'($urandom));
    endtask

    task automatic idle_inputs();
        i_start = 0; i_write = 0; i_block_mode = 0; i_block_size = 0; i_count = 0;
        i_abort = 0; i_rd_stb = 0; i_rd_data = 0; i_com_rdy = 1; i_finished = 0;
        i_phy_wr_stb = 0; i_phy_wr_data = 0; i_phy_rd_rdy = 1; i_crc_ok = 0; i_crc_err = 0;
    endtask

    task automatic start_xfer(input bit wr, input bit bm, input logic [11:0] bs, input logic [8:0] cnt);
        i_write = wr; i_block_mode = bm; i_block_size = bs; i_count = cnt;
        i_start = 1;
        cyc();
        i_start = 0;
    endtask

    // Phy side of the write path: offers exp_data bytes until `size` have been accepted.
    task automatic write_block(input int size);
        int sent = 0;
        for (int c = 0; c < size * 8 + 20 && sent < size; c++) begin
            i_com_rdy = ($urandom_range(0, 3) != 0);
            i_phy_wr_stb = 1;
            i_phy_wr_data = exp_data[widx];
            @(negedge clk);
            if (o_phy_wr_rdy) begin
                sent++;
                widx++;
            end
            cyc();
        end
        i_phy_wr_stb = 0;
        i_com_rdy = 1;
    endtask

    task automatic pulse_crc(input bit ok, input bit err);
        i_crc_ok = ok; i_crc_err = err;
        cyc();
        i_crc_ok = 0; i_crc_err = 0;
    endtask

    // Function side of the read path: pushes exp_data while o_hst_rdy allows, until n bytes reach the phy.
    task automatic read_stream(input int n, input bit rand_rdy, input int budget, input bit inject);
        int sent = 0;
        for (int c = 0; c < budget && rd_q.size() < n; c++) begin
            i_phy_rd_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (sent < n && o_hst_rdy) begin
                i_rd_stb = 1; i_rd_data = exp_data[sent]; sent++;
            end else begin
                i_rd_stb = 0;
            end
            if (inject && $urandom_range(0, 7) == 0) begin
                i_write = 1; i_block_mode = 1; i_block_size = 0; i_start = 1;
            end else begin
                i_start = 0;
            end
            cyc();
        end
        i_rd_stb = 0; i_start = 0; i_phy_rd_rdy = 1;
    endtask

    task automatic run_finish(output bit err_at_done);
        for (int i = 0; i < 200 && !(o_busy && !o_activate); i++) cyc();
        i_finished = 1;
        for (int i = 0; i < 20 && !o_done; i++) cyc();
        err_at_done = o_error;
        i_finished = 0;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        i_rd_stb = 1; i_phy_wr_stb = 1; i_crc_ok = 1;
        rst = 1;
        cyc(); cyc();
        total++; if ({o_activate, o_wr_stb, o_wr_data, o_hst_rdy, o_phy_wr_rdy, o_phy_rd_stb, o_phy_rd_data, o_block_end, o_busy, o_done, o_error} !== 25'd0) begin bad++; $display("[TB] FAIL reset_outputs got=%0h want=0", {o_activate, o_wr_stb, o_wr_data, o_hst_rdy, o_phy_wr_rdy, o_phy_rd_stb, o_phy_rd_data, o_block_end, o_busy, o_done, o_error}); end
        rst = 0;
        cyc();
        total++; if ({o_activate, o_busy, o_done, o_error, o_hst_rdy, o_phy_wr_rdy} !== 6'd0) begin bad++; $display("[TB] FAIL idle_outputs got=%0h want=0", {o_activate, o_busy, o_done, o_error, o_hst_rdy, o_phy_wr_rdy}); end
        idle_inputs();
    endtask

    task automatic test_byte_read();
        bit err;
        clear_mon();
        exp_data = '{8'hA1, 8'hA2, 8'hA3};
        i_phy_rd_rdy = 1;
        start_xfer(1'b0, 1'b0, 12'd0, 9'd3);
        total++; if ({o_activate, o_busy} !== 2'b11) begin bad++; $display("[TB] FAIL start_activate got=%b want=11", {o_activate, o_busy}); end
        for (int k = 0; k < 3; k++) begin
            i_rd_stb = 1; i_rd_data = exp_data[k];
            cyc();
        end
        i_rd_stb = 0;
        run_finish(err);
        total++; if (rd_q.size() !== 3) begin bad++; $display("[TB] FAIL byte_read_len got=%0d want=3", rd_q.size()); end
        for (int i = 0; i < 3; i++) begin
            bit want_end;
            want_end = (i == 2);
            total++; if (rd_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL byte_read_data[%0d] got=%0h want=%0h", i, rd_q[i], exp_data[i]); end
            total++; if (rd_end_q[i] !== want_end) begin bad++; $display("[TB] FAIL byte_read_end[%0d] got=%0b want=%0b", i, rd_end_q[i], want_end); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL byte_read_done got=%0d want=1", done_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL byte_read_err got=%0b want=0", err); end
    endtask

    task automatic test_random_byte_read();
        bit err;
        int n, len;
        for (int rep = 0; rep < 4; rep++) begin
            clear_mon();
            n = (rep == 3) ? 512 : $urandom_range(1, 9);
            len = n;
            fill_data(n);
            start_xfer(1'b0, 1'b0, 12'($urandom), (n == 512) ? 9'd0 : 9'(n));
            read_stream(n, 1'b1, n * 8 + 50, 1'b1);
            run_finish(err);
            total++; if (rd_q.size() !== n) begin bad++; $display("[TB] FAIL rand_read_len got=%0d want=%0d", rd_q.size(), n); end
            for (int i = 0; i < n; i++) begin
                bit want_end;
                want_end = ((i + 1) % len) == 0;
                total++; if (rd_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL rand_read_data[%0d] got=%0h want=%0h", i, rd_q[i], exp_data[i]); end
                total++; if (rd_end_q[i] !== want_end) begin bad++; $display("[TB] FAIL rand_read_end[%0d] got=%0b want=%0b", i, rd_end_q[i], want_end); end
            end
            total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL rand_read_done got=%0d want=1", done_cnt); end
            total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rand_read_err got=%0b want=0", err); end
        end
    endtask

    task automatic test_block_write();
        bit err;
        int size, cnt;
        for (int t = 0; t < 3; t++) begin
            clear_mon();
            size = (t == 0) ? 4 : $urandom_range(1, 6);
            cnt  = (t == 0) ? 2 : $urandom_range(1, 3);
            fill_data(size * cnt);
            widx = 0;
            start_xfer(1'b1, 1'b1, 12'(size), 9'(cnt));
            for (int b = 0; b < cnt; b++) begin
                write_block(size);
                #1;
                total++; if (o_phy_wr_rdy !== 1'b0) begin bad++; $display("[TB] FAIL blk_wait_rdy got=%0b want=0", o_phy_wr_rdy); end
                pulse_crc(1'b1, 1'b0);
            end
            run_finish(err);
            total++; if (wr_q.size() !== size * cnt) begin bad++; $display("[TB] FAIL write_len got=%0d want=%0d", wr_q.size(), size * cnt); end
            for (int i = 0; i < size * cnt; i++) begin
                bit want_end;
                want_end = ((i + 1) % size) == 0;
                total++; if (wr_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL write_data[%0d] got=%0h want=%0h", i, wr_q[i], exp_data[i]); end
                total++; if (wr_end_q[i] !== want_end) begin bad++; $display("[TB] FAIL write_end[%0d] got=%0b want=%0b", i, wr_end_q[i], want_end); end
            end
            total++; if (blk_ends !== cnt) begin bad++; $display("[TB] FAIL write_blocks got=%0d want=%0d", blk_ends, cnt); end
            total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL write_done got=%0d want=1", done_cnt); end
            total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL write_err got=%0b want=0", err); end
        end
    endtask

    task automatic test_overflow();
        bit err;
        bit want_rdy, want_err;
        int held;
        clear_mon();
        fill_data(6);
        i_phy_rd_rdy = 0;
        start_xfer(1'b0, 1'b0, 12'd0, 9'd6);
        total++; if (o_hst_rdy !== 1'b1) begin bad++; $display("[TB] FAIL ovf_rdy_empty got=%0b want=1", o_hst_rdy); end
        for (int k = 0; k < 6; k++) begin
            i_rd_stb = 1; i_rd_data = exp_data[k];
            cyc();
            held = (k + 1 < DEPTH) ? k + 1 : DEPTH;
            want_rdy = (DEPTH - held) >= 2;
            want_err = (k + 1) > DEPTH;
            total++; if (o_hst_rdy !== want_rdy) begin bad++; $display("[TB] FAIL ovf_hst_rdy[%0d] got=%0b want=%0b", k, o_hst_rdy, want_rdy); end
            total++; if (o_error !== want_err) begin bad++; $display("[TB] FAIL ovf_error[%0d] got=%0b want=%0b", k, o_error, want_err); end
        end
        i_rd_stb = 0;
        i_phy_rd_rdy = 1;
        repeat (8) cyc();
        i_abort = 1;
        cyc();
        i_abort = 0;
        total++; if ({o_activate, o_busy} !== 2'b01) begin bad++; $display("[TB] FAIL ovf_abort_state got=%b want=01", {o_activate, o_busy}); end
        run_finish(err);
        total++; if (rd_q.size() !== DEPTH) begin bad++; $display("[TB] FAIL ovf_len got=%0d want=%0d", rd_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (rd_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL ovf_data[%0d] got=%0h want=%0h", i, rd_q[i], exp_data[i]); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL ovf_done got=%0d want=1", done_cnt); end
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL ovf_err got=%0b want=1", err); end
    endtask

    task automatic test_crc_error();
        bit err;
        int size, cnt;
        for (int v = 0; v < 2; v++) begin
            clear_mon();
            size = (v == 0) ? 4 : 2;
            cnt  = (v == 0) ? 3 : 2;
            fill_data(size * cnt);
            widx = 0;
            start_xfer(1'b1, 1'b1, 12'(size), 9'(cnt));
            write_block(size);
            pulse_crc(v == 1, 1'b1);
            i_com_rdy = 1; i_phy_wr_stb = 1; i_phy_wr_data = 8'h5A;
            cyc(); cyc();
            total++; if (o_phy_wr_rdy !== 1'b0) begin bad++; $display("[TB] FAIL crc_rdy[%0d] got=%0b want=0", v, o_phy_wr_rdy); end
            total++; if ({o_activate, o_error} !== 2'b01) begin bad++; $display("[TB] FAIL crc_state[%0d] got=%b want=01", v, {o_activate, o_error}); end
            i_phy_wr_stb = 0;
            run_finish(err);
            total++; if (wr_q.size() !== size) begin bad++; $display("[TB] FAIL crc_len[%0d] got=%0d want=%0d", v, wr_q.size(), size); end
            total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL crc_done[%0d] got=%0d want=1", v, done_cnt); end
            total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL crc_err[%0d] got=%0b want=1", v, err); end
        end
    endtask

    task automatic test_abort_unbounded();
        bit err;
        clear_mon();
        fill_data(10);
        start_xfer(1'b0, 1'b1, 12'd4, 9'd0);
        read_stream(10, 1'b0, 100, 1'b0);
        total++; if (o_activate !== 1'b1) begin bad++; $display("[TB] FAIL unb_active got=%0b want=1", o_activate); end
        i_abort = 1;
        cyc();
        i_abort = 0;
        total++; if (o_activate !== 1'b0) begin bad++; $display("[TB] FAIL unb_abort got=%0b want=0", o_activate); end
        run_finish(err);
        total++; if (rd_q.size() !== 10) begin bad++; $display("[TB] FAIL unb_len got=%0d want=10", rd_q.size()); end
        for (int i = 0; i < 10; i++) begin
            bit want_end;
            want_end = ((i + 1) % 4) == 0;
            total++; if (rd_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL unb_data[%0d] got=%0h want=%0h", i, rd_q[i], exp_data[i]); end
            total++; if (rd_end_q[i] !== want_end) begin bad++; $display("[TB] FAIL unb_end[%0d] got=%0b want=%0b", i, rd_end_q[i], want_end); end
        end
        total++; if (blk_ends !== 2) begin bad++; $display("[TB] FAIL unb_blocks got=%0d want=2", blk_ends); end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL unb_done got=%0d want=1", done_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL unb_err got=%0b want=0", err); end
    endtask

    task automatic test_bad_size();
        bit err;
        logic [11:0] sizes [3];
        sizes[0] = 12'd0;
        sizes[1] = 12'd2049;
        sizes[2] = 12'($urandom_range(2050, 4095));
        for (int s = 0; s < 3; s++) begin
            clear_mon();
            start_xfer(s[0], 1'b1, sizes[s], 9'($urandom));
            total++; if ({o_done, o_error, o_activate, o_busy} !== 4'b1100) begin bad++; $display("[TB] FAIL bad_size_first[%0d] got=%b want=1100", s, {o_done, o_error, o_activate, o_busy}); end
            cyc();
            total++; if ({o_done, o_error, o_activate} !== 3'b010) begin bad++; $display("[TB] FAIL bad_size_after[%0d] got=%b want=010", s, {o_done, o_error, o_activate}); end
        end
        clear_mon();
        start_xfer(1'b1, 1'b1, 12'd2048, 9'd1);
        total++; if ({o_activate, o_busy, o_error} !== 3'b110) begin bad++; $display("[TB] FAIL max_size_start got=%b want=110", {o_activate, o_busy, o_error}); end
        i_abort = 1;
        cyc();
        i_abort = 0;
        run_finish(err);
        total++; if ({done_cnt == 1, err} !== 2'b10) begin bad++; $display("[TB] FAIL max_size_end got=%0d/%0b want=1/0", done_cnt, err); end
    endtask

    task automatic test_reset_mid();
        bit err;
        clear_mon();
        fill_data(8);
        widx = 0;
        start_xfer(1'b1, 1'b1, 12'd4, 9'd2);
        write_block(2);
        i_com_rdy = 1; i_phy_wr_stb = 1; i_phy_wr_data = 8'hC3; i_rd_stb = 1;
        rst = 1;
        cyc();
        total++; if ({o_activate, o_wr_stb, o_wr_data, o_hst_rdy, o_phy_wr_rdy, o_phy_rd_stb, o_phy_rd_data, o_block_end, o_busy, o_done, o_error} !== 25'd0) begin bad++; $display("[TB] FAIL mid_reset_outputs got=%0h want=0", {o_activate, o_wr_stb, o_wr_data, o_hst_rdy, o_phy_wr_rdy, o_phy_rd_stb, o_phy_rd_data, o_block_end, o_busy, o_done, o_error}); end
        rst = 0;
        idle_inputs();
        cyc();
        clear_mon();
        fill_data(3);
        widx = 0;
        start_xfer(1'b1, 1'b0, 12'd0, 9'd3);
        write_block(3);
        pulse_crc(1'b1, 1'b0);
        run_finish(err);
        total++; if (wr_q.size() !== 3) begin bad++; $display("[TB] FAIL restart_len got=%0d want=3", wr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (wr_q[i] !== exp_data[i]) begin bad++; $display("[TB] FAIL restart_data[%0d] got=%0h want=%0h", i, wr_q[i], exp_data[i]); end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("[TB] FAIL restart_done got=%0d want=1", done_cnt); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL restart_err got=%0b want=0", err); end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        blk_ends = 0;
        done_cnt = 0;
        widx = 0;
        test_reset();
        test_byte_read();
        test_random_byte_read();
        test_block_write();
        test_overflow();
        test_crc_error();
        test_abort_unbounded();
        test_bad_size();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
